cest_avg_buff_cee: RTL and testbench

- Parametrised channel-estimate buffer between the channel estimator and the equalizer.
- Accumulates 2^LOG2_AVG training symbols of DEPTH signed per-subcarrier estimates and commits their average into a ping-pong output bank.
- The equalizer reads the committed estimate by address with 1-cycle latency, while the next estimate accumulates in the background.

---
 rtl/cee_buff_pkg.sv | 18 +
 rtl/cee_dp_bank.sv | 30 +++
 rtl/cest_avg_buff_cee.sv | 167 ++++++++++++++++
 tb/tb_cest_avg_buff_cee.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cee_buff_pkg.sv
// Shared types and constants for the channel-estimate averaging buffer.
// The default geometry is also used by the equalizer side.
package cee_buff_pkg;

    localparam int CEE_DATA_W = 8;
    localparam int CEE_DEPTH  = 28;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } cee_state_e;

    // The sum of 2^log2_avg DATA_W-bit values needs log2_avg extra bits.
    function automatic int cee_acc_w(input int data_w, input int log2_avg);
        return data_w + log2_avg;
    endfunction

endpackage

// File: rtl/cee_dp_bank.sv
// Simple dual-port RAM, DEPTH x DATA_W: synchronous write, registered read.
// The read register holds its value when re is low.
module cee_dp_bank
    import cee_buff_pkg::*;
#(
    parameter int DATA_W = CEE_DATA_W,
    parameter int DEPTH  = CEE_DEPTH,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cest_avg_buff_cee.sv
// Channel-estimate averaging buffer: accumulates 2^LOG2_AVG training symbols
// per subcarrier and commits the average into a ping-pong bank that the
// equalizer reads with one cycle of latency.
// Optional build macro CEE_BUFF_ROUND_EN: round-half-up instead of floor.
module cest_avg_buff_cee
    import cee_buff_pkg::*;
#(
    parameter int DATA_W   = CEE_DATA_W,
    parameter int DEPTH    = CEE_DEPTH,
    parameter int ADDR_W   = 5,
    parameter int LOG2_AVG = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     rd_en,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     est_ready,
    output logic                     est_done
);

    localparam int ACC_W = cee_acc_w(DATA_W, LOG2_AVG);
    localparam int SYM_W = LOG2_AVG + 1;
    localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'((1 << LOG2_AVG) - 1);
    localparam logic [ADDR_W-1:0] SC_LAST  = ADDR_W'(DEPTH - 1);
`ifdef CEE_BUFF_ROUND_EN
    localparam int RND_I = (1 << LOG2_AVG) >> 1;
`else
    localparam int RND_I = 0;
`endif
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(RND_I);

    cee_state_e state_q, state_d;
    logic [ADDR_W-1:0] sc_cnt_q, sc_cnt_d;
    logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic bank_sel_q, bank_sel_d;
    logic est_done_q, est_done_d;
    logic est_ready_q, est_ready_d;
    logic rd_valid_q, rd_valid_d;
    logic rd_ok_q, rd_ok_d;
    logic rd_sel_q, rd_sel_d;

    logic signed [ACC_W-1:0] acc_q [DEPTH];
    logic signed [ACC_W-1:0] in_ext, acc_sum;
    logic signed [ACC_W:0]   sum_rnd;
    logic [DATA_W-1:0]       avg_data;
    logic                    final_sym, acc_we, bank_we;
    logic [1:0]              bank_wen;
    logic                    rd_in_range;
    logic [1:0][DATA_W-1:0]  bank_rdata;

    // Datapath: running sum for the current subcarrier and its scaled average.
    always_comb begin
        final_sym = (sym_cnt_q == SYM_LAST);
        in_ext    = ACC_W'(in_data);
        acc_sum   = (sym_cnt_q == '0) ? in_ext : acc_q[sc_cnt_q] + in_ext;
        sum_rnd   = (ACC_W + 1)'(acc_sum) + RND;
        avg_data  = DATA_W'(sum_rnd >>> LOG2_AVG);
    end

    // Control FSM: sample counting, accumulate/commit decisions, restart.
    always_comb begin
        state_d     = state_q;
        sc_cnt_d    = sc_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        bank_sel_d  = bank_sel_q;
        est_done_d  = 1'b0;
        est_ready_d = est_ready_q;
        acc_we      = 1'b0;
        bank_we     = 1'b0;
        if (start) begin
            // Restart drops any partial sums and the coincident sample.
            state_d   = ACCUM;
            sc_cnt_d  = '0;
            sym_cnt_d = '0;
        end else if (state_q == ACCUM && in_valid) begin
            acc_we  = !final_sym;
            bank_we = final_sym;
            if (sc_cnt_q == SC_LAST) begin
                sc_cnt_d = '0;
                if (final_sym) begin
                    state_d     = IDLE;
                    sym_cnt_d   = '0;
                    bank_sel_d  = !bank_sel_q;
                    est_done_d  = 1'b1;
                    est_ready_d = 1'b1;
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end else begin
                sc_cnt_d = sc_cnt_q + 1'b1;
            end
        end
    end

    // Read control: capture bank and masking at request time so a read
    // issued before the toggle still returns the old estimate.
    always_comb begin
        rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
        rd_valid_d  = rd_en;
        rd_ok_d     = rd_ok_q;
        rd_sel_d    = rd_sel_q;
        if (rd_en) begin
            rd_ok_d  = est_ready_q && rd_in_range;
            rd_sel_d = bank_sel_q;
        end
        bank_wen = bank_we ? (bank_sel_q ? 2'b01 : 2'b10) : 2'b00;
    end

    // Control and read-side state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sc_cnt_q    <= '0;
            sym_cnt_q   <= '0;
            bank_sel_q  <= 1'b0;
            est_done_q  <= 1'b0;
            est_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_ok_q     <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_cnt_q    <= sc_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            bank_sel_q  <= bank_sel_d;
            est_done_q  <= est_done_d;
            est_ready_q <= est_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_ok_q     <= rd_ok_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    // Accumulator array; first symbol overwrites, so no reset or clear pass.
    always_ff @(posedge clk) begin
        if (acc_we) acc_q[sc_cnt_q] <= acc_sum;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cee_dp_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_wen[b]),
            .waddr (sc_cnt_q),
            .wdata (avg_data),
            .re    (rd_en && rd_in_range),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign rd_data   = rd_ok_q ? $signed(bank_rdata[rd_sel_q]) : '0;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q == ACCUM);
    assign est_ready = est_ready_q;
    assign est_done  = est_done_q;

endmodule

// File: tb/tb_cest_avg_buff_cee.sv
// Directed bench for cest_avg_buff_cee: table of 4-symbol estimation runs
// plus hand-written sequences for background reads, restart and reset.
module tb_cest_avg_buff_cee;

`ifdef CEE_BUFF_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              start, in_valid, rd_en;
    logic signed [7:0] in_data;
    logic        [4:0] rd_addr;
    logic signed [7:0] rd_data;
    logic              rd_valid, busy, est_ready, est_done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0][7:0] s0;   // per-symbol value for every subcarrier except 1
        logic [3:0][7:0] s1;   // per-symbol value for subcarrier 1
        int              e0;
        int              e1;
    } vec_t;
    vec_t vecs [7];

    cest_avg_buff_cee #(
        .DATA_W(8), .DEPTH(28), .ADDR_W(5), .LOG2_AVG(2)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid),
        .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .est_ready(est_ready), .est_done(est_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (est_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input int exp, input string nm);
        rd_en = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({nm, "_valid"}, int'(rd_valid), 1);
        chk(nm, int'(rd_data), exp);
    endtask

    // One estimation of table entry idx, stopping after nsamp samples.
    // With rdc set, addr 5 is read every cycle and checked against old_v
    // up to the commit cycle and new_v right after it.
    task automatic run_est(input int idx, input int nsamp, input bit rdc,
                           input int old_v, input int new_v);
        int n;
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'sd99;          // coincides with start: must be dropped
        rd_en = rdc;
        rd_addr = 5'd5;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        if (rdc) chk("rd_old_start", int'(rd_data), old_v);
        n = 0;
        for (int sym = 0; sym < 4; sym++) begin
            for (int sc = 0; sc < 28; sc++) begin
                if (n < nsamp) begin
                    in_valid = 1'b1;
                    in_data = (sc == 1) ? vecs[idx].s1[sym] : vecs[idx].s0[sym];
                    tick();
                    n++;
                    if (rdc) chk("rd_old_bg", int'(rd_data), old_v);
                end
            end
        end
        in_valid = 1'b0;
        if (nsamp < 112) begin
            rd_en = 1'b0;
            chk("no_done_partial", done_cnt, d0);
            return;
        end
        chk("est_done_pulse", int'(est_done), 1);
        chk("busy_clear", int'(busy), 0);
        chk("est_ready_set", int'(est_ready), 1);
        tick();
        rd_en = 1'b0;
        chk("est_done_one_cycle", int'(est_done), 0);
        if (rdc) chk("rd_new_after_done", int'(rd_data), new_v);
        chk("done_count", done_cnt, d0 + 1);
    endtask

    initial begin
        vecs[0] = '{s0: 32'h291E140A, s1: 32'h291E140A, e0: 25, e1: 25};
        vecs[1] = '{s0: 32'h80808080, s1: 32'h7F7F7F7F, e0: -128, e1: 127};
        vecs[2] = '{s0: 32'hFEFFFFFF, s1: 32'h02030303,
                    e0: ROUND ? -1 : -2, e1: ROUND ? 3 : 2};
        vecs[3] = '{s0: 32'h01020202, s1: 32'hFFFEFEFE,
                    e0: ROUND ? 2 : 1, e1: -2};
        vecs[4] = '{s0: 32'h32323232, s1: 32'h32323232, e0: 50, e1: 50};
        vecs[5] = '{s0: 32'h07070707, s1: 32'h07070707, e0: 7, e1: 7};
        vecs[6] = '{s0: 32'h63636363, s1: 32'h63636363, e0: 0, e1: 0};

        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_est_ready", int'(est_ready), 0);
        chk("rst_est_done", int'(est_done), 0);
        rstn = 1'b1;
        tick();

        // Read before any commit, and in_valid while idle is ignored.
        in_valid = 1'b1; in_data = 8'sd5;
        rd(5'd3, 0, "rd_pre_commit");
        in_valid = 1'b0;
        chk("pre_est_ready", int'(est_ready), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_done", done_cnt, 0);
        tick();
        chk("rd_valid_drop", int'(rd_valid), 0);
        chk("rd_data_hold", int'(rd_data), 0);

        // Table of complete estimations.
        for (int i = 0; i < 4; i++) begin
            run_est(i, 112, 1'b0, 0, 0);
            rd(5'd0, vecs[i].e0, "rd_sc0");
            rd(5'd1, vecs[i].e1, "rd_sc1");
            rd(5'd27, vecs[i].e0, "rd_sc27");
            tick();
            chk("rd_hold_value", int'(rd_data), vecs[i].e0);
        end
        rd(5'd28, 0, "rd_oob28");
        rd(5'd31, 0, "rd_oob31");

        // Background estimation while the old one is read every cycle.
        run_est(4, 112, 1'b1, vecs[3].e0, 50);
        rd(5'd1, 50, "rd_sc1_after_bg");

        // Abort mid second symbol, then complete a run of 7.
        run_est(6, 38, 1'b1, 50, 0);
        chk("busy_after_abort_part", int'(busy), 1);
        run_est(5, 112, 1'b1, 50, 7);
        rd(5'd1, 7, "rd_restart_sc1");

        // Asynchronous reset in the middle of accumulation.
        run_est(0, 50, 1'b1, 7, 0);
        chk("pre_rst_rd_valid", int'(rd_valid), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_est_ready", int'(est_ready), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_rd_data", int'(rd_data), 0);
        chk("arst_est_done", int'(est_done), 0);
        tick();
        rstn = 1'b1;
        tick();
        rd(5'd5, 0, "rd_masked_after_rst");
        run_est(0, 112, 1'b0, 0, 0);
        rd(5'd5, 25, "rd_after_rst_run");
        rd(5'd1, 25, "rd_after_rst_sc1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
